// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response and data-RAM bus between the datapath and mem_access_ctrl
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
  logic req, we, sign, busy, done, err, mem_rd, mem_wr;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr, mem_addr;
  logic [31:0] wdata, rdata, mem_wdata, mem_rdata;
  modport master (
    output req, we, size, sign, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
  );
  modport slave (
    input  req, we, size, sign, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns one byte/half/word load or store into timed RAM strobes (RMW for sub-word stores).
// Define MEM_ACC_SIGNEXT_EN to honour sign on sub-word loads; otherwise they always zero-extend.
module mem_access_ctrl #(parameter int ADDR_W = 32) (
  input logic clk,
  input logic rst_n,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, WHOLD, DONE} state_t;
  state_t state, next;
  logic we_q, ext, accept, bad;
  logic [1:0] size_q, lo_q;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] wdata_q, merged, loaded;
  assign accept = state == IDLE && bus.req;
  assign bad = bus.size == 2'b11 || (bus.size == 2'b01 && bus.addr[0]) ||
               (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
`ifdef MEM_ACC_SIGNEXT_EN
  logic sign_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sign_q <= 1'b0;
    else if (accept) sign_q <= bus.sign;
  assign ext = sign_q;
`else
  assign ext = 1'b0;
`endif
  assign b = bus.mem_rdata[{lo_q, 3'b000} +: 8];
  assign h = bus.mem_rdata[{lo_q[1], 4'b0000} +: 16];
  assign loaded = size_q == 2'b00 ? {{24{ext & b[7]}}, b} :
                  size_q == 2'b01 ? {{16{ext & h[15]}}, h} : bus.mem_rdata;
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == 2'b00) merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else merged[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !bus.req ? IDLE : bad ? DONE : (bus.we && bus.size == 2'b10) ? WR : RD;
      RD:      next = we_q ? WR : DONE;
      WR:      next = WHOLD;
      WHOLD:   next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // Strobes are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.mem_rd <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.rdata <= '0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      we_q <= 1'b0;
      size_q <= 2'b00;
      lo_q <= 2'b00;
      wdata_q <= '0;
    end else begin
      bus.busy <= next != IDLE;
      bus.done <= next == DONE;
      bus.mem_rd <= next == RD;
      bus.mem_wr <= next == WR;
      bus.err <= accept && bad;
      if (accept) begin
        we_q <= bus.we;
        size_q <= bus.size;
        lo_q <= bus.addr[1:0];
        wdata_q <= bus.wdata;
        bus.mem_addr <= {bus.addr[ADDR_W-1:2], 2'b00};
        if (bad) bus.rdata <= '0;
        else if (bus.we && bus.size == 2'b10) bus.mem_wdata <= bus.wdata;
      end
      if (state == RD) begin
        if (we_q) bus.mem_wdata <= merged;
        else bus.rdata <= loaded;
      end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector table, multi-cycle corner sequences and randomized ops against a word-array reference model.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mem_access_ctrl_if #(.ADDR_W(32)) bus();
  mem_access_ctrl #(.ADDR_W(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] wr_addr = '0;
  int rd_cnt = 0, wr_cnt = 0, checks = 0, failures = 0;
  always_comb bus.mem_rdata = bus.mem_rd ? ram[bus.mem_addr[11:2]] : 32'h0;
  always @(posedge bus.mem_wr) begin
    ram[bus.mem_addr[11:2]] = bus.mem_wdata;
    wr_addr = bus.mem_addr;
    wr_cnt++;
  end
  always @(posedge bus.mem_rd) rd_cnt++;
  always @(negedge clk) begin
    checks++;
    if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) begin
      failures++;
      $display("FAIL rd_wr_overlap got=11 exp=not both high");
    end
  end
  typedef struct {
    logic we; logic [1:0] size; logic sign;
    logic [31:0] addr, wdata, pre, rd, mem;
    logic err; int lat, nrd, nwr;
  } vec_t;
  vec_t tbl [9];
  function automatic vec_t mk(logic we, logic [1:0] size, logic sign, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] pre, logic err, logic [31:0] rd, logic [31:0] mem, int lat, int nrd, int nwr);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata; v.pre = pre;
    v.err = err; v.rd = rd; v.mem = mem; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < 20) begin
      @(negedge clk);
      g++;
    end
  endtask
  task automatic run(input logic we, input logic [1:0] size, input logic sign, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic err, output logic [31:0] rd, output int lat);
    bus.we = we; bus.size = size; bus.sign = sign; bus.addr = addr; bus.wdata = wdata; bus.req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus.req = 1'b0;
      lat++;
    end while (!bus.done && lat < 10);
    err = bus.err;
    rd = bus.rdata;
  endtask
  function automatic void ref_op(input logic we, input logic [1:0] size, input logic sign, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic err, output logic [31:0] out, output int lat);
    int off = int'(addr % 4);
    logic [31:0] mask, w;
    err = size == 3 || (size == 1 && addr % 2 == 1) || (size == 2 && off != 0);
    out = 0;
    lat = 1;
    if (err) return;
    mask = size == 0 ? 32'hFF : size == 1 ? 32'hFFFF : 32'hFFFF_FFFF;
    w = ref_mem[addr[11:2]];
    if (we) begin
      ref_mem[addr[11:2]] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      lat = size == 2 ? 3 : 4;
    end else begin
      out = (w >> (8 * off)) & mask;
`ifdef MEM_ACC_SIGNEXT_EN
      if (sign && size != 2 && (out & ((mask >> 1) + 1)) != 0) out = out | ~mask;
`endif
      lat = 2;
    end
  endfunction
`ifdef MEM_ACC_SIGNEXT_EN
  localparam logic [31:0] HALF_SX = 32'hFFFF_807F;
`else
  localparam logic [31:0] HALF_SX = 32'h0000_807F;
`endif
  initial begin
    logic e;
    logic [31:0] r, er;
    int lat, elat, idx, r0, w0, n;
    logic [1:0] sz;
    bus.req = 0; bus.we = 0; bus.size = 0; bus.sign = 0; bus.addr = 0; bus.wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    tbl[0] = mk(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h0, 32'hDEADBEEF, 3, 0, 1);
    tbl[1] = mk(0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1, 0);
    tbl[2] = mk(1, 2'd0, 0, 32'h202, 32'hAB,       32'h11223344, 0, 32'h0, 32'h11AB3344, 4, 1, 1);
    tbl[3] = mk(0, 2'd1, 1, 32'h300, 32'h0,        32'h0000807F, 0, HALF_SX, 32'h0000807F, 2, 1, 0);
    tbl[4] = mk(0, 2'd0, 0, 32'h301, 32'h0,        32'h0000807F, 0, 32'h80, 32'h0000807F, 2, 1, 0);
    tbl[5] = mk(0, 2'd2, 0, 32'h102, 32'h0,        32'h12345678, 1, 32'h0, 32'h12345678, 1, 0, 0);
    tbl[6] = mk(1, 2'd1, 0, 32'h203, 32'hFFFF,     32'h9ABCDEF0, 1, 32'h0, 32'h9ABCDEF0, 1, 0, 0);
    tbl[7] = mk(0, 2'd3, 0, 32'h100, 32'h0,        32'h0BADF00D, 1, 32'h0, 32'h0BADF00D, 1, 0, 0);
    tbl[8] = mk(1, 2'd1, 0, 32'h302, 32'h1234CAFE, 32'h11223344, 0, 32'h0, 32'hCAFE3344, 4, 1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_err", {31'b0, bus.err}, 0);
    chk("rst_rd", {31'b0, bus.mem_rd}, 0);
    chk("rst_wr", {31'b0, bus.mem_wr}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_mwdata", bus.mem_wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      idx = int'(tbl[i].addr[11:2]);
      ram[idx] = tbl[i].pre;
      ref_mem[idx] = tbl[i].mem;
      r0 = rd_cnt;
      w0 = wr_cnt;
      run(tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wdata, e, r, lat);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, tbl[i].err});
      if (!tbl[i].we || tbl[i].err) chk($sformatf("v%0d_rdata", i), r, tbl[i].rd);
      repeat (2) @(posedge clk);
      chk($sformatf("v%0d_mem", i), ram[idx], tbl[i].mem);
      chk($sformatf("v%0d_nrd", i), rd_cnt - r0, tbl[i].nrd);
      chk($sformatf("v%0d_nwr", i), wr_cnt - w0, tbl[i].nwr);
      if (tbl[i].nwr != 0) chk($sformatf("v%0d_waddr", i), wr_addr, tbl[i].addr & ~32'h3);
    end
    // req held high through a word store: the second request must wait for the IDLE after DONE
    wait_idle();
    ram[32'h140 >> 2] = 0; ram[32'h180 >> 2] = 0;
    ref_mem[32'h140 >> 2] = 32'h11111111; ref_mem[32'h180 >> 2] = 32'h22222222;
    w0 = wr_cnt;
    bus.we = 1; bus.size = 2; bus.sign = 0; bus.addr = 32'h140; bus.wdata = 32'h11111111; bus.req = 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin bus.addr = 32'h180; bus.wdata = 32'h22222222; end
    end while (!bus.done && n < 10);
    chk("busy_lat1", n, 3);
    chk("busy_nwr1", wr_cnt - w0, 1);
    chk("busy_waddr1", wr_addr, 32'h140);
    chk("busy_mem1", ram[32'h140 >> 2], 32'h11111111);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 10);
    bus.req = 0;
    chk("busy_gap2", n, 4);
    chk("busy_nwr2", wr_cnt - w0, 2);
    chk("busy_mem2", ram[32'h180 >> 2], 32'h22222222);
    // async reset while a byte store is in its read phase
    wait_idle();
    idx = 32'h200 >> 2;
    ram[idx] = 32'h55667788;
    ref_mem[idx] = 32'h55667788;
    w0 = wr_cnt;
    bus.we = 1; bus.size = 0; bus.sign = 0; bus.addr = 32'h201; bus.wdata = 32'hAA; bus.req = 1;
    @(posedge clk); #1;
    bus.req = 0;
    chk("rrd_rd", {31'b0, bus.mem_rd}, 1);
    chk("rrd_busy", {31'b0, bus.busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rrd_rd0", {31'b0, bus.mem_rd}, 0);
    chk("rrd_busy0", {31'b0, bus.busy}, 0);
    chk("rrd_done0", {31'b0, bus.done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("rrd_nwr", wr_cnt - w0, 0);
    chk("rrd_mem", ram[idx], 32'h55667788);
    for (int i = 0; i < 300; i++) begin
      logic rwe, rsg;
      logic [31:0] ra, rw;
      rwe = 1'($urandom);
      rsg = 1'($urandom);
      n = $urandom_range(0, 7);
      sz = n == 7 ? 2'd3 : 2'(n % 3);
      ra = $urandom_range(0, 4095);
      rw = $urandom;
      ref_op(rwe, sz, rsg, ra, rw, er[0], r, elat);
      wait_idle();
      run(rwe, sz, rsg, ra, rw, e, er, lat);
      chk($sformatf("rnd%0d_lat", i), lat, elat);
      ref_op(rwe, sz, rsg, ra, rw, e, r, elat);
      chk($sformatf("rnd%0d_err", i), {31'b0, bus.err}, {31'b0, e});
      if (!rwe || e) chk($sformatf("rnd%0d_rdata", i), er, r);
      repeat (2) @(posedge clk);
      chk($sformatf("rnd%0d_mem", i), ram[ra[11:2]], ref_mem[ra[11:2]]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
